mem_block_responder: RTL and testbench

Memory-side responder for the external memory request channel that the internal memory controller's comm buffer drives. It accepts single-word or block requests (`mem_req`/`mem_reqBlock`/`mem_rw`/`mem_add`) and returns `mem_ready`/`mem_valid`/`mem_done` with read data. It services each request against a synchronous single-port SRAM with 1-cycle read latency. It sits between the comm buffer's `mem_*` pins and the backing SRAM, and is used both on board and as the memory model in system simulation.

---
 rtl/mem_block_responder.sv | 206 ++++++++++++++++++++
 tb/tb_mem_block_responder.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_block_responder.sv
// mem_block_responder
// Memory-side responder for the comm buffer's external request channel.
// Accepts single-word or aligned block requests and services them against a
// synchronous single-port SRAM with one cycle of read latency. All outputs
// are registered; reset aborts any transfer in progress.

module mem_block_responder #(
   parameter int BLOCK_WORDS = 4,
   parameter int ADDR_W      = 14
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              mem_req_i,
   input  logic              mem_reqBlock_i,
   input  logic              mem_rw_i,
   input  logic              mem_clear_i,
   input  logic [23:0]       mem_add_i,
   input  logic [31:0]       mem_data_i,
   output logic              mem_ready_o,
   output logic              mem_valid_o,
   output logic              mem_done_o,
   output logic [31:0]       mem_data_o,
   output logic              err_o,
   output logic              sram_en_o,
   output logic              sram_we_o,
   output logic [ADDR_W-1:0] sram_add_o,
   output logic [31:0]       sram_data_o,
   input  logic [31:0]       sram_data_i
);

   localparam int OFF_W = $clog2(BLOCK_WORDS);
   localparam int CNT_W = OFF_W + 1;
   localparam logic [ADDR_W-1:0] ALIGN_MASK  = ~(ADDR_W'(BLOCK_WORDS - 1));
   localparam logic [CNT_W-1:0]  BLOCK_BEATS = CNT_W'(BLOCK_WORDS);
   localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE,
      RD,
      WR,
      DONE
   } stateT;

   stateT             state,     stateN;
   logic              readyQ,    readyN;
   logic              validQ,    validN;
   logic              doneQ,     doneN;
   logic [31:0]       dataOutQ,  dataOutN;
   logic              errQ,      errN;
   logic              sramEnQ,   sramEnN;
   logic              sramWeQ,   sramWeN;
   logic [ADDR_W-1:0] sramAddQ,  sramAddN;
   logic [31:0]       sramDataQ, sramDataN;
   logic [ADDR_W-1:0] baseQ,     baseN;
   logic [CNT_W-1:0]  numQ,      numN;
   logic [CNT_W-1:0]  issueQ,    issueN;
   logic [CNT_W-1:0]  beatQ,     beatN;
   logic              rdPendQ,   rdPendN;

   logic [23:0]       upperBits;
   logic [ADDR_W-1:0] acceptBase;

   // Bits above the SRAM range are dropped (the SRAM aliases) but flag an error;
   // block requests are forced onto an aligned burst boundary.
   assign upperBits  = mem_add_i >> ADDR_W;
   assign acceptBase = mem_reqBlock_i ? (mem_add_i[ADDR_W-1:0] & ALIGN_MASK)
                                      : mem_add_i[ADDR_W-1:0];

   // State register and all registered outputs; reset drops the SRAM strobes
   // immediately so an aborted write burst stops mid-flight.
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         state     <= IDLE;
         readyQ    <= 1'b0;
         validQ    <= 1'b0;
         doneQ     <= 1'b0;
         dataOutQ  <= '0;
         errQ      <= 1'b0;
         sramEnQ   <= 1'b0;
         sramWeQ   <= 1'b0;
         sramAddQ  <= '0;
         sramDataQ <= '0;
         baseQ     <= '0;
         numQ      <= '0;
         issueQ    <= '0;
         beatQ     <= '0;
         rdPendQ   <= 1'b0;
      end else begin
         state     <= stateN;
         readyQ    <= readyN;
         validQ    <= validN;
         doneQ     <= doneN;
         dataOutQ  <= dataOutN;
         errQ      <= errN;
         sramEnQ   <= sramEnN;
         sramWeQ   <= sramWeN;
         sramAddQ  <= sramAddN;
         sramDataQ <= sramDataN;
         baseQ     <= baseN;
         numQ      <= numN;
         issueQ    <= issueN;
         beatQ     <= beatN;
         rdPendQ   <= rdPendN;
      end
   end

   // Next-state and next-output logic. A read returns one cycle after the SRAM
   // samples the address, so rdPend marks the cycle in which sram_data_i holds
   // a word that must be registered onto mem_data_o.
   always_comb begin
      stateN    = state;
      readyN    = readyQ;
      validN    = 1'b0;
      doneN     = doneQ;
      dataOutN  = dataOutQ;
      errN      = errQ;
      sramEnN   = 1'b0;
      sramWeN   = 1'b0;
      sramAddN  = sramAddQ;
      sramDataN = sramDataQ;
      baseN     = baseQ;
      numN      = numQ;
      issueN    = issueQ;
      beatN     = beatQ;
      rdPendN   = sramEnQ & ~sramWeQ;

      case (state)
         IDLE: begin
            readyN = 1'b1;
            doneN  = 1'b0;
            if (mem_req_i) begin
               readyN = 1'b0;
               baseN  = acceptBase;
               numN   = mem_reqBlock_i ? BLOCK_BEATS : CNT_ONE;
               beatN  = '0;
               issueN = '0;
               if (|upperBits) begin
                  errN = 1'b1;
               end
               if (mem_rw_i) begin
                  stateN = WR;
                  validN = 1'b1;
               end else begin
                  stateN   = RD;
                  sramEnN  = 1'b1;
                  sramAddN = acceptBase;
                  issueN   = CNT_ONE;
               end
            end
         end

         RD: begin
            if (issueQ < numQ) begin
               sramEnN  = 1'b1;
               sramAddN = baseQ + ADDR_W'(issueQ);
               issueN   = issueQ + CNT_ONE;
            end
            if (rdPendQ) begin
               dataOutN = sram_data_i;
               validN   = 1'b1;
               beatN    = beatQ + CNT_ONE;
            end else if (beatQ == numQ) begin
               stateN = DONE;
               doneN  = 1'b1;
            end
         end

         WR: begin
            validN    = 1'b1;
            sramEnN   = 1'b1;
            sramWeN   = 1'b1;
            sramAddN  = baseQ + ADDR_W'(beatQ);
            sramDataN = mem_data_i;
            beatN     = beatQ + CNT_ONE;
            if (beatQ == numQ - CNT_ONE) begin
               validN = 1'b0;
               stateN = DONE;
               doneN  = 1'b1;
            end
         end

         DONE: begin
            if (mem_clear_i) begin
               stateN = IDLE;
               doneN  = 1'b0;
               readyN = 1'b1;
            end
         end

         default: begin
            stateN = IDLE;
         end
      endcase
   end

   assign mem_ready_o = readyQ;
   assign mem_valid_o = validQ;
   assign mem_done_o  = doneQ;
   assign mem_data_o  = dataOutQ;
   assign err_o       = errQ;
   assign sram_en_o   = sramEnQ;
   assign sram_we_o   = sramWeQ;
   assign sram_add_o  = sramAddQ;
   assign sram_data_o = sramDataQ;

endmodule

// File: tb/tb_mem_block_responder.sv
// tb_mem_block_responder
// Directed bench for mem_block_responder with a behavioural SRAM. Expected
// read words and SRAM writes go into queues as stimulus is issued; a monitor
// pops and compares them whenever the DUT presents a read beat or SRAM write.

module tb_mem_block_responder;

   logic        clock_i = 1'b0;
   logic        reset_i;
   logic        mem_req_i;
   logic        mem_reqBlock_i;
   logic        mem_rw_i;
   logic        mem_clear_i;
   logic [23:0] mem_add_i;
   logic [31:0] mem_data_i;
   logic        mem_ready_o;
   logic        mem_valid_o;
   logic        mem_done_o;
   logic [31:0] mem_data_o;
   logic        err_o;
   logic        sram_en_o;
   logic        sram_we_o;
   logic [13:0] sram_add_o;
   logic [31:0] sram_data_o;
   logic [31:0] sram_data_i;

   typedef struct {
      logic [13:0] add;
      logic [31:0] data;
   } wrExpT;

   logic [31:0] expRdQ [$];
   wrExpT       expWrQ [$];

   int checks = 0;
   int errors = 0;
   int rdPulses = 0;
   bit txnIsWrite = 1'b0;

   // Free-running clock
   always #5 clock_i = ~clock_i;

   mem_block_responder #(
      .BLOCK_WORDS(4),
      .ADDR_W(14)
   ) dut (
      .clock_i(clock_i),
      .reset_i(reset_i),
      .mem_req_i(mem_req_i),
      .mem_reqBlock_i(mem_reqBlock_i),
      .mem_rw_i(mem_rw_i),
      .mem_clear_i(mem_clear_i),
      .mem_add_i(mem_add_i),
      .mem_data_i(mem_data_i),
      .mem_ready_o(mem_ready_o),
      .mem_valid_o(mem_valid_o),
      .mem_done_o(mem_done_o),
      .mem_data_o(mem_data_o),
      .err_o(err_o),
      .sram_en_o(sram_en_o),
      .sram_we_o(sram_we_o),
      .sram_add_o(sram_add_o),
      .sram_data_o(sram_data_o),
      .sram_data_i(sram_data_i)
   );

   // Small SRAM model (aliases on the low 6 address bits); preloaded with
   // 0xC0000000+index on its first edge, read data valid the cycle after.
   logic [31:0] sramMem [64];
   logic [31:0] sramRdData = '0;
   bit          sramInit = 1'b0;

   always @(posedge clock_i) begin
      if (!sramInit) begin
         for (int i = 0; i < 64; i++) begin
            sramMem[i] <= 32'hC000_0000 + 32'(i);
         end
         sramInit <= 1'b1;
      end else if (sram_en_o) begin
         if (sram_we_o) begin
            sramMem[sram_add_o[5:0]] <= sram_data_o;
         end else begin
            sramRdData <= sramMem[sram_add_o[5:0]];
         end
      end
   end

   assign sram_data_i = sramRdData;

   task automatic checkWord(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic checkOutput(input string name, input logic actual, input logic expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0b, expected %0b", name, actual, expected);
      end
   endtask

   // Monitor: scoreboard comparison of read beats and SRAM writes
   always @(negedge clock_i) begin
      if (reset_i === 1'b1) begin
         if (mem_valid_o && !txnIsWrite) begin
            rdPulses++;
            if (expRdQ.size() == 0) begin
               checkWord("rdUnexpectedBeat", mem_data_o, 32'h0);
               checkOutput("rdUnexpectedValid", mem_valid_o, 1'b0);
            end else begin
               checkWord("rdData", mem_data_o, expRdQ.pop_front());
            end
         end
         if (sram_en_o && sram_we_o) begin
            if (expWrQ.size() == 0) begin
               checkOutput("wrUnexpected", sram_we_o, 1'b0);
            end else begin
               wrExpT e;
               e = expWrQ.pop_front();
               checkWord("wrAdd", 32'(sram_add_o), 32'(e.add));
               checkWord("wrData", sram_data_o, e.data);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock_i);
      #1;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "Ready"}, mem_ready_o, 1'b0);
      checkOutput({tag, "Valid"}, mem_valid_o, 1'b0);
      checkOutput({tag, "Done"}, mem_done_o, 1'b0);
      checkWord({tag, "DataOut"}, mem_data_o, 32'h0);
      checkOutput({tag, "Err"}, err_o, 1'b0);
      checkOutput({tag, "SramEn"}, sram_en_o, 1'b0);
      checkOutput({tag, "SramWe"}, sram_we_o, 1'b0);
      checkWord({tag, "SramAdd"}, 32'(sram_add_o), 32'h0);
      checkWord({tag, "SramData"}, sram_data_o, 32'h0);
   endtask

   task automatic clearDone();
      mem_clear_i = 1'b1;
      tick();
      mem_clear_i = 1'b0;
      checkOutput("clrDone", mem_done_o, 1'b0);
      checkOutput("clrReady", mem_ready_o, 1'b1);
   endtask

   task automatic waitDone(input int maxCycles);
      int c = 0;
      while (!mem_done_o && c < maxCycles) begin
         tick();
         c++;
      end
      checkOutput("waitDone", mem_done_o, 1'b1);
   endtask

   // Write transaction with cycle-exact checks of valid/done/SRAM strobes
   task automatic applyStimulus(input logic [23:0] addr, input logic block, input logic [31:0] words [4]);
      int n;
      logic [13:0] base;
      n = block ? 4 : 1;
      base = addr[13:0];
      if (block) base[1:0] = 2'b00;
      for (int k = 0; k < n; k++) begin
         expWrQ.push_back('{add: base + 14'(k), data: words[k]});
      end
      txnIsWrite = 1'b1;
      checkOutput("wrReadyBefore", mem_ready_o, 1'b1);
      mem_req_i = 1'b1;
      mem_reqBlock_i = block;
      mem_rw_i = 1'b1;
      mem_add_i = addr;
      mem_data_i = words[0];
      tick();
      mem_req_i = 1'b0;
      checkOutput("wrReadyE0", mem_ready_o, 1'b0);
      checkOutput("wrValidE0", mem_valid_o, 1'b1);
      checkOutput("wrSramEnE0", sram_en_o, 1'b0);
      for (int k = 0; k < n; k++) begin
         tick();
         checkOutput("wrWe", sram_we_o, 1'b1);
         checkWord("wrAddTiming", 32'(sram_add_o), 32'(base + 14'(k)));
         checkOutput("wrValid", mem_valid_o, k < n - 1);
         checkOutput("wrDone", mem_done_o, k == n - 1);
         if (k + 1 < n) mem_data_i = words[k + 1];
      end
      tick();
      checkOutput("wrSramEnAfter", sram_en_o, 1'b0);
      checkOutput("wrDoneHeld", mem_done_o, 1'b1);
   endtask

   // Read transaction with cycle-exact checks; optional held request and a
   // stray clear pulse during RD, both of which must be ignored
   task automatic readTxn(input logic [23:0] addr, input logic block, input logic [31:0] words [4],
                          input bit holdReq, input bit clearPulse);
      int n;
      logic [13:0] base;
      n = block ? 4 : 1;
      base = addr[13:0];
      if (block) base[1:0] = 2'b00;
      for (int k = 0; k < n; k++) expRdQ.push_back(words[k]);
      txnIsWrite = 1'b0;
      rdPulses = 0;
      checkOutput("rdReadyBefore", mem_ready_o, 1'b1);
      mem_req_i = 1'b1;
      mem_reqBlock_i = block;
      mem_rw_i = 1'b0;
      mem_add_i = addr;
      tick();
      if (!holdReq) mem_req_i = 1'b0;
      checkOutput("rdReadyE0", mem_ready_o, 1'b0);
      checkOutput("rdSramEnE0", sram_en_o, 1'b1);
      checkOutput("rdSramWeE0", sram_we_o, 1'b0);
      checkWord("rdSramAddE0", 32'(sram_add_o), 32'(base));
      for (int i = 1; i <= n + 2; i++) begin
         if (clearPulse && i == 1) mem_clear_i = 1'b1;
         tick();
         mem_clear_i = 1'b0;
         checkOutput("rdValid", mem_valid_o, (i >= 2) && (i <= n + 1));
         checkOutput("rdDone", mem_done_o, i == n + 2);
         if (i < n) begin
            checkOutput("rdSramEn", sram_en_o, 1'b1);
            checkWord("rdSramAdd", 32'(sram_add_o), 32'(base + 14'(i)));
         end else begin
            checkOutput("rdSramEnOff", sram_en_o, 1'b0);
         end
      end
      checkWord("rdPulseCount", 32'(rdPulses), 32'(n));
   endtask

   // Watchdog so the run always terminates
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] wA [4];
      logic [31:0] wS [4];
      logic [31:0] wE [4];
      logic [31:0] wB [4];
      logic [31:0] wBr [4];

      wA  = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
      wS  = '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0};
      wE  = '{32'hC000_0002, 32'h0, 32'h0, 32'h0};
      wB  = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
      wBr = '{32'hB0, 32'hB1, 32'hC000_0022, 32'hC000_0023};

      reset_i = 1'b0;
      mem_req_i = 1'b0;
      mem_reqBlock_i = 1'b0;
      mem_rw_i = 1'b0;
      mem_clear_i = 1'b0;
      mem_add_i = '0;
      mem_data_i = '0;

      $display("[TB] reset");
      repeat (3) tick();
      checkAllZero("rst");
      reset_i = 1'b1;
      checkOutput("rstReadyBeforeEdge", mem_ready_o, 1'b0);
      tick();
      checkOutput("rstReadyAfterEdge", mem_ready_o, 1'b1);
      checkOutput("rstErr", err_o, 1'b0);

      $display("[TB] block write 0x13 then block read 0x10");
      applyStimulus(24'h000013, 1'b1, wA);
      clearDone();
      readTxn(24'h000010, 1'b1, wA, 1'b0, 1'b0);
      clearDone();

      $display("[TB] single word write/read");
      applyStimulus(24'h000005, 1'b0, wS);
      clearDone();
      readTxn(24'h000005, 1'b0, wS, 1'b0, 1'b0);
      checkWord("singleDataHeld", mem_data_o, 32'hDEADBEEF);
      clearDone();

      $display("[TB] ignored controls");
      readTxn(24'h000010, 1'b1, wA, 1'b1, 1'b1);
      tick();
      checkOutput("holdReqDone", mem_done_o, 1'b1);
      checkOutput("holdReqNoAccept", mem_ready_o, 1'b0);
      mem_clear_i = 1'b1;
      tick();
      mem_clear_i = 1'b0;
      checkOutput("clrReqReady", mem_ready_o, 1'b1);
      checkOutput("clrReqDone", mem_done_o, 1'b0);
      checkOutput("clrReqSramEn", sram_en_o, 1'b0);
      for (int k = 0; k < 4; k++) expRdQ.push_back(wA[k]);
      tick();
      mem_req_i = 1'b0;
      checkOutput("reAcceptReady", mem_ready_o, 1'b0);
      checkOutput("reAcceptSramEn", sram_en_o, 1'b1);
      waitDone(20);
      clearDone();

      $display("[TB] address error");
      readTxn(24'h800002, 1'b0, wE, 1'b0, 1'b0);
      checkOutput("errSet", err_o, 1'b1);
      clearDone();
      readTxn(24'h000005, 1'b0, wS, 1'b0, 1'b0);
      checkOutput("errSticky", err_o, 1'b1);
      clearDone();

      $display("[TB] reset mid block write");
      expWrQ.push_back('{add: 14'h20, data: wB[0]});
      expWrQ.push_back('{add: 14'h21, data: wB[1]});
      txnIsWrite = 1'b1;
      mem_req_i = 1'b1;
      mem_reqBlock_i = 1'b1;
      mem_rw_i = 1'b1;
      mem_add_i = 24'h000022;
      mem_data_i = wB[0];
      tick();
      mem_req_i = 1'b0;
      tick();
      mem_data_i = wB[1];
      tick();
      mem_data_i = wB[2];
      tick();
      checkOutput("midWeBefore", sram_we_o, 1'b1);
      reset_i = 1'b0;
      #1;
      checkAllZero("midRst");
      tick();
      tick();
      reset_i = 1'b1;
      tick();
      checkOutput("midRelReady", mem_ready_o, 1'b1);
      checkOutput("midRelDone", mem_done_o, 1'b0);
      checkOutput("midRelErr", err_o, 1'b0);
      readTxn(24'h000020, 1'b1, wBr, 1'b0, 1'b0);
      clearDone();

      tick();
      checkWord("rdQueueEmpty", 32'(expRdQ.size()), 32'h0);
      checkWord("wrQueueEmpty", 32'(expWrQ.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
